// File: rtl/time_disp_driver.sv
// Time-of-day to 4-digit multiplexed 7-segment driver with a double-dabble BCD converter.
// Optional build macro TIME_DISP_HR12_EN shows hour 0 as "12" in HH:MM mode.
module time_disp_driver #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic [26:0] disp_time,
    input  logic        mode,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StLoad, StConv, StDone} state_e;

    state_e      state_q, state_d;
    logic [17:0] key_q;
    logic        force_q;
    logic [16:0] snap_q;
    logic        snap_mode_q;
    logic [5:0]  bin_hi_q, bin_lo_q;
    logic [7:0]  bcd_hi_q, bcd_lo_q;
    logic [2:0]  iter_q;
    logic [15:0] dig_q;
    logic        blank_q, err_q, busy_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q;

    logic [17:0] key_live;
    logic [4:0]  s_hr;
    logic [5:0]  s_min, s_sec;
    logic        oor, new_blank;
    logic [15:0] new_dig;
    logic [3:0]  cur_dig;
    logic        unused_ms;

    assign key_live  = {disp_time[26:10], mode};
    assign unused_ms = ^disp_time[9:0];
    assign s_hr      = snap_q[16:12];
    assign s_min     = snap_q[11:6];
    assign s_sec     = snap_q[5:0];

    // One shift-add-3 step on a two-digit BCD accumulator; tens never exceeds 6.
    function automatic logic [7:0] dd_step(input logic [7:0] bcd, input logic b);
        logic [3:0] t, u;
        t = bcd[7:4];
        u = bcd[3:0];
        if (t >= 4'd5) t = t + 4'd3;
        if (u >= 4'd5) u = u + 4'd3;
        return {t[2:0], u, b};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (force_q || (key_live != key_q)) state_d = StLoad;
            StLoad: state_d = StConv;
            StConv: if (iter_q == 3'd5) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        oor       = (s_hr > 5'd23) || (s_min > 6'd59) || (s_sec > 6'd59);
        new_dig   = {bcd_hi_q, bcd_lo_q};
        new_blank = !snap_mode_q && (bcd_hi_q[7:4] == 4'd0);
`ifdef TIME_DISP_HR12_EN
        if (!snap_mode_q && (s_hr == 5'd0)) begin
            new_dig[15:8] = 8'h12;
            new_blank     = 1'b0;
        end
`endif
    end

    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            key_q       <= '0;
            force_q     <= 1'b1;
            snap_q      <= '0;
            snap_mode_q <= 1'b0;
            bin_hi_q    <= '0;
            bin_lo_q    <= '0;
            bcd_hi_q    <= '0;
            bcd_lo_q    <= '0;
            iter_q      <= '0;
            dig_q       <= '0;
            blank_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: if (state_d == StLoad) busy_q <= 1'b1;
                StLoad: begin
                    snap_q      <= disp_time[26:10];
                    snap_mode_q <= mode;
                    bin_hi_q    <= mode ? disp_time[21:16] : {1'b0, disp_time[26:22]};
                    bin_lo_q    <= mode ? disp_time[15:10] : disp_time[21:16];
                    bcd_hi_q    <= '0;
                    bcd_lo_q    <= '0;
                    iter_q      <= '0;
                    busy_q      <= 1'b1;
                end
                StConv: begin
                    bcd_hi_q <= dd_step(bcd_hi_q, bin_hi_q[5]);
                    bcd_lo_q <= dd_step(bcd_lo_q, bin_lo_q[5]);
                    bin_hi_q <= {bin_hi_q[4:0], 1'b0};
                    bin_lo_q <= {bin_lo_q[4:0], 1'b0};
                    iter_q   <= iter_q + 3'd1;
                end
                StDone: begin
                    dig_q   <= new_dig;
                    blank_q <= new_blank;
                    err_q   <= oor;
                    key_q   <= {snap_q, snap_mode_q};
                    force_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Scan path: an/seg/dp all computed from the next digit index so they change together.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        idx_d = idx_q;
        if (cnt_q >= 8'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q - 2'd1;
        end
        unique case (idx_d)
            2'd3:    cur_dig = dig_q[15:12];
            2'd2:    cur_dig = dig_q[11:8];
            2'd1:    cur_dig = dig_q[7:4];
            default: cur_dig = dig_q[3:0];
        endcase
        if (err_q) seg_d = 7'b0111111;
        else if ((idx_d == 2'd3) && blank_q) seg_d = 7'b1111111;
        else seg_d = seg_of(cur_dig);
    end

    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= ~(4'b0001 << idx_d);
            seg_q <= seg_d;
            dp_q  <= !((idx_d == 2'd2) && !snap_q[0]);
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_time_disp_driver.sv
// Randomized self-checking bench for time_disp_driver against an arithmetic display model.
module tb_time_disp_driver;
    localparam int unsigned ScanDiv = 4;

    logic        kh_clk = 1'b0;
    logic        reset = 1'b0;
    logic [26:0] disp_time = '0;
    logic        mode = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, busy, err;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    time_disp_driver #(.SCAN_DIV(ScanDiv)) dut (
        .kh_clk(kh_clk), .reset(reset), .disp_time(disp_time), .mode(mode),
        .an(an), .seg(seg), .dp(dp), .busy(busy), .err(err)
    );

    always #5 kh_clk = ~kh_clk;

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected segment pattern per digit slot (slot i at bits i*7), err flag and dp per slot.
    function automatic void model(input int hr, input int mn, input int sc, input logic md,
                                  output logic [27:0] segs, output logic e,
                                  output logic [3:0] dps);
        int hi, lo;
        hi = md ? mn : hr;
        lo = md ? sc : mn;
        e = (hr > 23) || (mn > 59) || (sc > 59);
        dps = (sc % 2 == 0) ? 4'b1011 : 4'b1111;
        if (e) begin
            segs = {4{7'b0111111}};
        end else begin
            segs = {seg_ref(hi / 10), seg_ref(hi % 10), seg_ref(lo / 10), seg_ref(lo % 10)};
            if (!md && hi / 10 == 0) segs[27:21] = 7'b1111111;
`ifdef TIME_DISP_HR12_EN
            if (!md && hr == 0) segs[27:14] = {seg_ref(1), seg_ref(2)};
`endif
        end
    endfunction

    task automatic apply(input int hr, input int mn, input int sc, input logic md);
        @(negedge kh_clk);
        disp_time = {5'(hr), 6'(mn), 6'(sc), 10'($urandom_range(0, 999))};
        mode = md;
    endtask

    task automatic wait_conv(input string name);
        int n = 0;
        @(negedge kh_clk);
        @(negedge kh_clk);
        while (busy && n < 30) begin
            @(negedge kh_clk);
            n++;
        end
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL %s: busy still %b after bound, required 0", name, busy);
        end
    endtask

    // Watches two full scan rounds and records what each slot displayed.
    task automatic capture(output logic [27:0] segs, output logic [3:0] dps, output int bad);
        logic [3:0] seen = 4'b0;
        int i;
        segs = '1;
        dps  = '1;
        bad  = 0;
        for (int c = 0; c < 8 * ScanDiv; c++) begin
            @(negedge kh_clk);
            case (an)
                4'b0111: i = 3;
                4'b1011: i = 2;
                4'b1101: i = 1;
                4'b1110: i = 0;
                default: i = -1;
            endcase
            if (i < 0) bad++;
            else begin
                segs[i*7 +: 7] = seg;
                dps[i] = dp;
                seen[i] = 1'b1;
            end
        end
        if (seen != 4'hF) bad++;
    endtask

    task automatic test_display(input string name, input int hr, input int mn, input int sc,
                                input logic md);
        logic [27:0] es, gs;
        logic [3:0]  ed, gd;
        logic        ee;
        int          bad;
        model(hr, mn, sc, md, es, ee, ed);
        capture(gs, gd, bad);
        vecs++;
        if (gs !== es) begin
            errs++;
            $display("FAIL %s segs: got %h required %h", name, gs, es);
        end
        vecs++;
        if (err !== ee) begin
            errs++;
            $display("FAIL %s err: got %b required %b", name, err, ee);
        end
        vecs++;
        if (gd !== ed) begin
            errs++;
            $display("FAIL %s dp: got %b required %b", name, gd, ed);
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL %s an: %0d bad scan samples, required 0", name, bad);
        end
    endtask

    task automatic test_reset();
        int nbusy = 0;
        reset = 1'b0;
        repeat (3) @(negedge kh_clk);
        vecs++;
        if ({an, seg, dp, busy, err} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_outputs: got an=%b seg=%b dp=%b busy=%b err=%b required 1111 1111111 1 0 0",
                     an, seg, dp, busy, err);
        end
        disp_time = {5'd9, 6'd41, 6'd7, 10'd0};
        mode = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge kh_clk);
            if (busy) nbusy++;
        end
        vecs++;
        if (nbusy != 8) begin
            errs++;
            $display("FAIL reset_busy_len: got %0d cycles required 8", nbusy);
        end
        test_display("reset_first", 9, 41, 7, 1'b0);
    endtask

    task automatic test_mode_latency();
        int  n = 0;
        bit  seen = 0;
        @(negedge kh_clk);
        mode = 1'b1;
        while (n < 14) begin
            @(negedge kh_clk);
            n++;
            if (busy) seen = 1;
            if (seen && !busy) break;
        end
        vecs++;
        if (!seen || n != 9) begin
            errs++;
            $display("FAIL mode_latency: got %0d edges (busy seen %0d) required 9", n, seen);
        end
        test_display("mode1", 9, 41, 7, 1'b1);
        apply(9, 41, 8, 1'b1);
        wait_conv("sec8");
        test_display("sec8_colon", 9, 41, 8, 1'b1);
    endtask

    task automatic test_hr0();
        apply(0, 5, 3, 1'b0);
        wait_conv("hr0");
        test_display("hr0", 0, 5, 3, 1'b0);
    endtask

    task automatic test_err();
        apply(9, 60, 10, 1'b0);
        wait_conv("min60");
        test_display("min60_err", 9, 60, 10, 1'b0);
        apply(9, 59, 10, 1'b0);
        wait_conv("min59");
        test_display("min59_ok", 9, 59, 10, 1'b0);
    endtask

    task automatic test_reset_mid();
        apply(25, 10, 10, 1'b0);
        wait_conv("pre_err");
        apply(12, 34, 56, 1'b1);
        repeat (4) @(negedge kh_clk);
        #2 reset = 1'b0;
        #1;
        vecs++;
        if ({an, seg, dp, busy, err} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL mid_reset_outputs: got an=%b seg=%b dp=%b busy=%b err=%b required 1111 1111111 1 0 0",
                     an, seg, dp, busy, err);
        end
        @(negedge kh_clk);
        reset = 1'b1;
        wait_conv("mid_reset_restart");
        test_display("mid_reset_after", 12, 34, 56, 1'b1);
    endtask

    task automatic test_scan();
        logic [3:0] prev, nxt;
        int         run = 0;
        bit         started = 0;
        @(negedge kh_clk);
        prev = an;
        for (int c = 0; c < 40; c++) begin
            @(negedge kh_clk);
            if (an === prev) run++;
            else begin
                nxt = {prev[0], prev[3:1]};
                if (started) begin
                    vecs++;
                    if (run != ScanDiv || an !== nxt) begin
                        errs++;
                        $display("FAIL scan: %b held %0d then %b, required %0d then %b",
                                 prev, run, an, ScanDiv, nxt);
                    end
                end
                started = 1;
                run = 1;
                prev = an;
            end
        end
    endtask

    task automatic test_random();
        int hr, mn, sc;
        logic md;
        for (int k = 0; k < 16; k++) begin
            hr = $urandom_range(0, 31);
            mn = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
            sc = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 59);
            md = 1'($urandom_range(0, 1));
            apply(hr, mn, sc, md);
            wait_conv("random");
            test_display("random", hr, mn, sc, md);
        end
    endtask

    initial begin
        test_reset();
        test_mode_latency();
        test_hr0();
        test_err();
        test_reset_mid();
        test_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
